time_counter_bcd: RTL and testbench

Parametrised, registered BCD timekeeping core for the digital alarm clock: a prescaler turns the system clock into one-second ticks that advance an hh:mm:ss BCD counter chain with carry, and a valid/ready command port loads or adjusts individual fields. It replaces the earlier purely combinational arithmetic top-level datapath. The block sits between the TinyTapeout top wrapper (pin mapping) and the display multiplexer.

---
 rtl/time_cnt_pkg.sv | 55 +++++
 rtl/time_counter_bcd_bcd_mod_counter.sv | 69 ++++++
 rtl/time_counter_bcd.sv | 210 +++++++++++++++++++++
 tb/tb_time_counter_bcd.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_cnt_pkg.sv
// time_cnt_pkg: shared types, BCD limits and helpers for the
// hh:mm:ss BCD timekeeping core.
package time_cnt_pkg;

  typedef enum logic [1:0] {
    FIELD_SEC = 2'b00,
    FIELD_MIN = 2'b01,
    FIELD_HR  = 2'b10,
    FIELD_RSV = 2'b11
  } field_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_INC  = 2'b01,
    OP_DEC  = 2'b10,
    OP_ZERO = 2'b11
  } op_e;

  localparam logic [7:0] BCD_MAX_MS = 8'h59;
  localparam logic [7:0] BCD_MAX_HR = 8'h23;

  // Both digits decimal and value no larger than max.
  // Valid BCD compares correctly as plain binary.
  function automatic logic bcd_valid(
    input logic [7:0] v,
    input logic [7:0] max
  );
    return (v[7:4] <= 4'd9) &&
           (v[3:0] <= 4'd9) &&
           (v <= max);
  endfunction

  function automatic logic [7:0] bin2bcd(
    input logic [6:0] b
  );
    return {4'(b / 7'd10), 4'(b % 7'd10)};
  endfunction

  // 24-hour BCD in, {pm, 12-hour BCD} out.
  function automatic logic [8:0] to_12h(
    input logic [7:0] h
  );
    logic [4:0] b;
    b = 5'(h[7:4]) * 5'd10 + 5'(h[3:0]);
    if (b == 5'd0)
      return {1'b0, 8'h12};
    else if (b < 5'd12)
      return {1'b0, bin2bcd(7'(b))};
    else if (b == 5'd12)
      return {1'b1, 8'h12};
    else
      return {1'b1, bin2bcd(7'(b - 5'd12))};
  endfunction

endpackage

// File: rtl/time_counter_bcd_bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter modulo MOD with load,
// field-local inc/dec and a chained carry for the tick path.
// Ports: clk, rst (sync, high), inc, dec, load, carry_in,
//   data[7:0] in; value[7:0], nxt[7:0], carry_out out.
//   nxt is the value the next edge will store.
module bcd_mod_counter
  import time_cnt_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       dec,
  input  logic       load,
  input  logic       carry_in,
  input  logic [7:0] data,
  output logic [7:0] value,
  output logic [7:0] nxt,
  output logic       carry_out
);

  localparam logic [7:0] MAXV = bin2bcd(7'(MOD - 1));

  logic [7:0] up;
  logic [7:0] dn;

  always_comb begin
    up = 8'h00;
    if (value == MAXV)
      up = 8'h00;
    else if (value[3:0] == 4'd9)
      up = {value[7:4] + 4'd1, 4'd0};
    else
      up = {value[7:4], value[3:0] + 4'd1};
  end

  always_comb begin
    dn = MAXV;
    if (value == 8'h00)
      dn = MAXV;
    else if (value[3:0] == 4'd0)
      dn = {value[7:4] - 4'd1, 4'd9};
    else
      dn = {value[7:4], value[3:0] - 4'd1};
  end

  // Commands and the tick path never coincide at the top,
  // so the order here only matters among command strobes.
  always_comb begin
    nxt = value;
    if (load)
      nxt = data;
    else if (inc || carry_in)
      nxt = up;
    else if (dec)
      nxt = dn;
  end

  assign carry_out = carry_in && (value == MAXV);

  always_ff @(posedge clk) begin
    if (rst)
      value <= 8'h00;
    else
      value <= nxt;
  end

endmodule

// File: rtl/time_counter_bcd.sv
// time_counter_bcd: prescaled hh:mm:ss BCD clock with a
// valid/ready command port for field load and adjust.
// Ports: clk, rst (sync, high), tick_en, cmd_valid/cmd_ready,
//   cmd_op[1:0], cmd_field[1:0], cmd_data[7:0] -> cmd_err,
//   sec_bcd, min_bcd, hr_bcd[7:0], pm, sec_pulse.
// Build option TIME_CNT_ALARM_EN adds alarm_hr_bcd[7:0],
//   alarm_min_bcd[7:0] inputs and the alarm_match output.
module time_counter_bcd
  import time_cnt_pkg::*;
#(
  parameter int TICK_DIV = 10_000_000,
  parameter bit HOUR_12  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [1:0] cmd_field,
  input  logic [7:0] cmd_data,
  output logic       cmd_err,
  output logic [7:0] sec_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic       pm,
  output logic       sec_pulse
`ifdef TIME_CNT_ALARM_EN
  ,
  input  logic [7:0] alarm_hr_bcd,
  input  logic [7:0] alarm_min_bcd,
  output logic       alarm_match
`endif
);

  localparam int PW =
    (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc;
  logic          tick_pend;
  logic          tick_raw;
  logic          fire;
  logic          apply;

  op_e    op;
  field_e fld;

  logic       rej;
  logic       ld_s, ld_m, ld_h;
  logic       inc_s, inc_m, inc_h;
  logic       dec_s, dec_m, dec_h;
  logic [7:0] ld_val;

  logic       c_s, c_m;
  logic [7:0] sec_nxt, min_nxt;
  logic [7:0] hr24, hr_nxt;
  logic       day_wrap;

  assign op  = op_e'(cmd_op);
  assign fld = field_e'(cmd_field);

  assign cmd_ready = !tick_pend;
  assign fire      = cmd_valid && cmd_ready;
  assign tick_raw  = tick_en && (presc == PMAX);

  // A pending tick blocks commands, so at most one of the
  // two tick sources is ever live when a command is applied.
  assign apply = tick_pend || (tick_raw && !fire);

  always_comb begin
    rej    = 1'b0;
    ld_s   = 1'b0;
    ld_m   = 1'b0;
    ld_h   = 1'b0;
    inc_s  = 1'b0;
    inc_m  = 1'b0;
    inc_h  = 1'b0;
    dec_s  = 1'b0;
    dec_m  = 1'b0;
    dec_h  = 1'b0;
    ld_val = cmd_data;
    if (fire) begin
      if (fld == FIELD_RSV) begin
        rej = 1'b1;
      end else begin
        unique case (op)
          OP_LOAD: begin
            if (!bcd_valid(cmd_data,
                  (fld == FIELD_HR) ? BCD_MAX_HR
                                    : BCD_MAX_MS)) begin
              rej = 1'b1;
            end else begin
              ld_s = (fld == FIELD_SEC);
              ld_m = (fld == FIELD_MIN);
              ld_h = (fld == FIELD_HR);
            end
          end
          OP_INC: begin
            inc_s = (fld == FIELD_SEC);
            inc_m = (fld == FIELD_MIN);
            inc_h = (fld == FIELD_HR);
          end
          OP_DEC: begin
            dec_s = (fld == FIELD_SEC);
            dec_m = (fld == FIELD_MIN);
            dec_h = (fld == FIELD_HR);
          end
          OP_ZERO: begin
            ld_s   = 1'b1;
            ld_val = 8'h00;
          end
        endcase
      end
    end
  end

  // ld_s covers both a good seconds load and op ZERO: both
  // restart the second and swallow a coincident tick.
  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (ld_s)
      presc <= '0;
    else if (tick_en)
      presc <= tick_raw ? '0 : presc + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst)
      tick_pend <= 1'b0;
    else
      tick_pend <= tick_raw && fire && !ld_s;
  end

  bcd_mod_counter #(.MOD(60)) u_sec (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_s),
    .dec       (dec_s),
    .load      (ld_s),
    .carry_in  (apply),
    .data      (ld_val),
    .value     (sec_bcd),
    .nxt       (sec_nxt),
    .carry_out (c_s)
  );

  bcd_mod_counter #(.MOD(60)) u_min (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_m),
    .dec       (dec_m),
    .load      (ld_m),
    .carry_in  (c_s),
    .data      (ld_val),
    .value     (min_bcd),
    .nxt       (min_nxt),
    .carry_out (c_m)
  );

  bcd_mod_counter #(.MOD(24)) u_hr (
    .clk       (clk),
    .rst       (rst),
    .inc       (inc_h),
    .dec       (dec_h),
    .load      (ld_h),
    .carry_in  (c_m),
    .data      (ld_val),
    .value     (hr24),
    .nxt       (hr_nxt),
    .carry_out (day_wrap)
  );

  // Hour view is formed from the counter's next value so the
  // displayed hour changes on the same edge as the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      hr_bcd    <= HOUR_12 ? 8'h12 : 8'h00;
      pm        <= 1'b0;
      sec_pulse <= 1'b0;
      cmd_err   <= 1'b0;
    end else begin
      {pm, hr_bcd} <= HOUR_12 ? to_12h(hr_nxt)
                              : {1'b0, hr_nxt};
      sec_pulse    <= apply;
      cmd_err      <= rej;
    end
  end

`ifdef TIME_CNT_ALARM_EN
  // Only tick-driven updates can match; loads never set apply.
  always_ff @(posedge clk) begin
    if (rst)
      alarm_match <= 1'b0;
    else
      alarm_match <= apply &&
                     (sec_nxt == 8'h00) &&
                     (min_nxt == alarm_min_bcd) &&
                     (hr_nxt == alarm_hr_bcd);
  end

  logic unused_sig;
  assign unused_sig = ^{hr24, day_wrap};
`else
  logic unused_sig;
  assign unused_sig = ^{hr24, day_wrap, sec_nxt, min_nxt};
`endif

endmodule

// File: tb/tb_time_counter_bcd.sv
// tb_time_counter_bcd: directed checks of the BCD time core,
// one 12-hour TICK_DIV=4 instance and one 24-hour TICK_DIV=1.
module tb_time_counter_bcd;

  logic       clk;
  logic       rst;
  logic       en_a, en_b;
  logic       cmd_valid;
  logic [1:0] cmd_op, cmd_field;
  logic [7:0] cmd_data;

  logic       rdy_a, err_a, pm_a, pls_a;
  logic [7:0] sec_a, min_a, hr_a;
  logic       rdy_b, err_b, pm_b, pls_b;
  logic [7:0] sec_b, min_b, hr_b;
`ifdef TIME_CNT_ALARM_EN
  logic [7:0] al_hr, al_min;
  logic       am_a, am_b;
`endif

  int vecs = 0;
  int errs = 0;

  time_counter_bcd #(.TICK_DIV(4), .HOUR_12(1'b1)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .tick_en   (en_a),
    .cmd_valid (cmd_valid),
    .cmd_ready (rdy_a),
    .cmd_op    (cmd_op),
    .cmd_field (cmd_field),
    .cmd_data  (cmd_data),
    .cmd_err   (err_a),
    .sec_bcd   (sec_a),
    .min_bcd   (min_a),
    .hr_bcd    (hr_a),
    .pm        (pm_a),
    .sec_pulse (pls_a)
`ifdef TIME_CNT_ALARM_EN
    ,
    .alarm_hr_bcd  (al_hr),
    .alarm_min_bcd (al_min),
    .alarm_match   (am_a)
`endif
  );

  time_counter_bcd #(.TICK_DIV(1), .HOUR_12(1'b0)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .tick_en   (en_b),
    .cmd_valid (cmd_valid),
    .cmd_ready (rdy_b),
    .cmd_op    (cmd_op),
    .cmd_field (cmd_field),
    .cmd_data  (cmd_data),
    .cmd_err   (err_b),
    .sec_bcd   (sec_b),
    .min_bcd   (min_b),
    .hr_bcd    (hr_b),
    .pm        (pm_b),
    .sec_pulse (pls_b)
`ifdef TIME_CNT_ALARM_EN
    ,
    .alarm_hr_bcd  (al_hr),
    .alarm_min_bcd (al_min),
    .alarm_match   (am_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string      tag,
    input logic [8:0] obs,
    input logic [8:0] exp
  );
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic cmd(
    input logic [1:0] op,
    input logic [1:0] fld,
    input logic [7:0] d
  );
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_field = fld;
    cmd_data  = d;
    cyc();
    cmd_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    en_a      = 1'b0;
    en_b      = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_field = 2'b00;
    cmd_data  = 8'h00;
`ifdef TIME_CNT_ALARM_EN
    al_hr  = 8'h07;
    al_min = 8'h30;
`endif
    cyc();
    cyc();
    rst = 1'b0;
    chk("rst_sec", sec_a, 8'h00);
    chk("rst_min", min_a, 8'h00);
    chk("rst_hr12", hr_a, 8'h12);
    chk("rst_pm", pm_a, 1'b0);
    chk("rst_pulse", pls_a, 1'b0);
    chk("rst_err", err_a, 1'b0);
    chk("rst_rdy", rdy_a, 1'b1);
    chk("rst_hr24", hr_b, 8'h00);

    // first tick after four enabled cycles
    en_a = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("tick_early", sec_a, 8'h00);
    cyc();
    chk("tick_sec", sec_a, 8'h01);
    chk("tick_pulse", pls_a, 1'b1);
    chk("tick_hr12", hr_a, 8'h12);
    en_a = 1'b0;
    cyc();
    chk("tick_pulse_off", pls_a, 1'b0);

    // 12-hour view
    cmd(2'b00, 2'b10, 8'h13);
    chk("h12_13_hr", hr_a, 8'h01);
    chk("h12_13_pm", pm_a, 1'b1);
    chk("h24_13_hr", hr_b, 8'h13);
    cmd(2'b00, 2'b10, 8'h00);
    chk("h12_00_hr", hr_a, 8'h12);
    chk("h12_00_pm", pm_a, 1'b0);

    // rejected commands
    cmd(2'b00, 2'b01, 8'h5A);
    chk("bad_min_err", err_b, 1'b1);
    chk("bad_min_err_a", err_a, 1'b1);
    chk("bad_min_val", min_b, 8'h00);
    cyc();
    chk("err_drop", err_a, 1'b0);
    cmd(2'b00, 2'b10, 8'h24);
    chk("bad_hr_err", err_b, 1'b1);
    chk("bad_hr_val", hr_b, 8'h00);
    cmd(2'b00, 2'b11, 8'h00);
    chk("rsv_err", err_a, 1'b1);

    // field-local wrap, no borrow/carry
    cmd(2'b10, 2'b01, 8'h00);
    chk("dec_min", min_b, 8'h59);
    chk("dec_min_hr", hr_b, 8'h00);
    chk("dec_min_err", err_b, 1'b0);
    cmd(2'b00, 2'b10, 8'h23);
    cmd(2'b01, 2'b10, 8'h00);
    chk("inc_hr", hr_b, 8'h00);
    chk("inc_hr_min", min_b, 8'h59);

    // day rollover with TICK_DIV=1
    cmd(2'b00, 2'b10, 8'h23);
    cmd(2'b00, 2'b01, 8'h59);
    cmd(2'b00, 2'b00, 8'h58);
    chk("ld_sec", sec_b, 8'h58);
    chk("ld_hr", hr_b, 8'h23);
    chk("h12_23_hr", hr_a, 8'h11);
    chk("h12_23_pm", pm_a, 1'b1);
    en_b = 1'b1;
    cyc();
    chk("roll1_sec", sec_b, 8'h59);
    chk("roll1_min", min_b, 8'h59);
    chk("roll1_hr", hr_b, 8'h23);
    cyc();
    en_b = 1'b0;
    chk("roll2_sec", sec_b, 8'h00);
    chk("roll2_min", min_b, 8'h00);
    chk("roll2_hr", hr_b, 8'h00);
    chk("roll2_pulse", pls_b, 1'b1);
    cyc();
    chk("stop_pulse", pls_b, 1'b0);
    chk("stop_sec", sec_b, 8'h00);

    // op 11 zeroes seconds and prescaler
    cmd(2'b11, 2'b00, 8'h77);
    chk("zero_sec", sec_a, 8'h00);

    // command in the wrap cycle defers the tick
    en_a = 1'b1;
    cyc();
    cyc();
    cyc();
    chk("pre_col_sec", sec_a, 8'h00);
    cmd(2'b01, 2'b01, 8'h00);
    chk("col_min", min_a, 8'h00);
    chk("col_sec", sec_a, 8'h00);
    chk("col_rdy", rdy_a, 1'b0);
    chk("col_pulse", pls_a, 1'b0);
    cyc();
    chk("pend_sec", sec_a, 8'h01);
    chk("pend_pulse", pls_a, 1'b1);
    chk("pend_rdy", rdy_a, 1'b1);
    chk("pend_hr", hr_a, 8'h11);

    // seconds load in the wrap cycle cancels the tick
    cyc();
    cyc();
    chk("pre_ld_sec", sec_a, 8'h01);
    cmd(2'b00, 2'b00, 8'h30);
    chk("wrap_ld_sec", sec_a, 8'h30);
    chk("wrap_ld_rdy", rdy_a, 1'b1);
    cyc();
    chk("cancel_sec", sec_a, 8'h30);
    chk("cancel_pulse", pls_a, 1'b0);
    cyc();
    cyc();
    chk("restart_early", sec_a, 8'h30);
    cyc();
    chk("restart_sec", sec_a, 8'h31);
    chk("restart_pulse", pls_a, 1'b1);

    // reset overrides a coincident command and tick
    rst = 1'b1;
    cmd(2'b00, 2'b01, 8'h45);
    rst  = 1'b0;
    en_a = 1'b0;
    chk("mid_rst_sec", sec_a, 8'h00);
    chk("mid_rst_min", min_a, 8'h00);
    chk("mid_rst_hr", hr_a, 8'h12);
    chk("mid_rst_rdy", rdy_a, 1'b1);

`ifdef TIME_CNT_ALARM_EN
    cmd(2'b00, 2'b10, 8'h07);
    cmd(2'b00, 2'b01, 8'h29);
    cmd(2'b00, 2'b00, 8'h59);
    chk("al_idle", am_b, 1'b0);
    en_b = 1'b1;
    cyc();
    chk("al_min", min_b, 8'h30);
    chk("al_hit", am_b, 1'b1);
    chk("al_pulse", pls_b, 1'b1);
    cyc();
    en_b = 1'b0;
    chk("al_once", am_b, 1'b0);
    cmd(2'b00, 2'b00, 8'h00);
    chk("al_ld_sec", sec_b, 8'h00);
    chk("al_ld_none", am_b, 1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

endmodule
